pipe_hazard_ctrl: RTL and testbench

Central pipeline controller for the 5-stage RV32 core (IF/ID/EX/MEM/WB). It keeps a registered scoreboard of the destination registers in flight. From that it drives the operand-forwarding selects, the load-use stall, the taken-branch/jump flush and the data-memory wait freeze. It replaces the ad-hoc rd buffering in the ID decode path; the decoder now only supplies decoded fields.

---
 rtl/pipe_hazard_ctrl_if.sv | 58 +++++
 rtl/pipe_hazard_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Groups the decoded ID fields and the EX/MEM status bits that feed the hazard
// controller, together with the pipeline control signals it returns.
//
// Signals
//   id_valid, id_rs1, id_rs2, id_rd      ID instruction fields
//   id_use_rs1, id_use_rs2               ID instruction reads rs1 / rs2
//   id_regwen, id_is_load                ID instruction writes rd / is a load
//   ex_redirect                          taken branch or jump resolved in EX
//   mem_access, dmem_ready               MEM holds LW/SW, memory completes
//   pc_en, ifid_en, exmem_en             register enables back to datapath
//   ifid_flush, idex_flush               bubble insertion
//   fwd_a, fwd_b                         operand forwarding selects
//   stall                                load-use stall indicator
//
// Modports
//   master : datapath / decoder side (drives ID fields and status)
//   slave  : hazard controller side
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       id_regwen;
    logic       id_is_load;
    logic       ex_redirect;
    logic       mem_access;
    logic       dmem_ready;

    logic       pc_en;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_en;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       stall;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd,
        output id_use_rs1, id_use_rs2, id_regwen, id_is_load,
        output ex_redirect, mem_access, dmem_ready,
        input  pc_en, ifid_en, ifid_flush, idex_flush, exmem_en,
        input  fwd_a, fwd_b, stall
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd,
        input  id_use_rs1, id_use_rs2, id_regwen, id_is_load,
        input  ex_redirect, mem_access, dmem_ready,
        output pc_en, ifid_en, ifid_flush, idex_flush, exmem_en,
        output fwd_a, fwd_b, stall
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central hazard controller for the 5-stage RV32 pipeline. Tracks destination
// registers in flight and derives forwarding selects, the load-use stall, the
// redirect flush and the data-memory wait freeze.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | normal issue
//   LDSTALL  | cycle after a load-use stall (the load has moved to MEM)
//   MEMWAIT  | data memory access outstanding, whole pipe frozen
//
// Ports
//   clk             core clock
//   rst             synchronous reset, active-high
//   hz              pipe_hazard_ctrl_if.slave (ID fields, status, controls)
//   perf_stall_cnt  load-use + memory-wait cycle count
//   perf_flush_cnt  accepted redirect count
//
// Optional build macro
//   PIPE_PERF_EN    enables the two performance counters; when undefined the
//                   counter ports are tied to zero and no counter flops exist.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int CNT_W       = 32,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz,
    output logic [CNT_W-1:0]  perf_stall_cnt,
    output logic [CNT_W-1:0]  perf_flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // Scoreboard slots. The WB stage is not held here: its writer reaches ID
    // through the regfile's write-first port, so no decision ever reads it.
    logic       ex_v;
    logic [4:0] ex_rd;
    logic       ex_wen;
    logic       ex_ld;
    logic       mem_v;
    logic [4:0] mem_rd;
    logic       mem_wen;

    logic       ex_match_a;
    logic       ex_match_b;
    logic       mem_match_a;
    logic       mem_match_b;
    logic [1:0] fwd_a_c;
    logic [1:0] fwd_b_c;
    logic       load_use;
    logic       mem_wait;

    logic       pc_en_c;
    logic       ifid_en_c;
    logic       ifid_flush_c;
    logic       idex_flush_c;
    logic       exmem_en_c;
    logic       stall_c;
    logic       ex_take;

    // Register x0 and non-writing slots can never be a producer.
    always_comb begin
        ex_match_a  = hz.id_use_rs1 && (hz.id_rs1 != 5'd0) && ex_v  && ex_wen  && (ex_rd  == hz.id_rs1);
        ex_match_b  = hz.id_use_rs2 && (hz.id_rs2 != 5'd0) && ex_v  && ex_wen  && (ex_rd  == hz.id_rs2);
        mem_match_a = hz.id_use_rs1 && (hz.id_rs1 != 5'd0) && mem_v && mem_wen && (mem_rd == hz.id_rs1);
        mem_match_b = hz.id_use_rs2 && (hz.id_rs2 != 5'd0) && mem_v && mem_wen && (mem_rd == hz.id_rs2);

        // A load in EX has no ALU result yet, so it falls through to MEM.
        if (ex_match_a && !ex_ld)
            fwd_a_c = 2'b10;
        else if (mem_match_a)
            fwd_a_c = 2'b11;
        else
            fwd_a_c = 2'b00;

        if (ex_match_b && !ex_ld)
            fwd_b_c = 2'b10;
        else if (mem_match_b)
            fwd_b_c = 2'b11;
        else
            fwd_b_c = 2'b00;

        load_use = hz.id_valid && ex_ld && (ex_match_a || ex_match_b);
        mem_wait = hz.mem_access && !hz.dmem_ready;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_RUN;
        else
            state <= state_nx;
    end

    // Priority: reset > memory wait > redirect > load-use > normal.
    always_comb begin
        state_nx     = ST_RUN;
        pc_en_c      = 1'b1;
        ifid_en_c    = 1'b1;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        exmem_en_c   = 1'b1;
        stall_c      = 1'b0;

        if (rst) begin
            state_nx = ST_RUN;
        end else if (mem_wait) begin
            // Redirect stays pending here; EX is frozen and keeps asserting it.
            pc_en_c    = 1'b0;
            ifid_en_c  = 1'b0;
            exmem_en_c = 1'b0;
            state_nx   = ST_MEMWAIT;
        end else if (hz.ex_redirect) begin
            // Squashing the consumer also cancels any load-use stall.
            ifid_flush_c = (FLUSH_DEPTH >= 1);
            idex_flush_c = (FLUSH_DEPTH >= 2);
        end else if (load_use && (state != ST_LDSTALL)) begin
            // The bubble just issued moves the load to MEM, so a second
            // consecutive stall can never be required.
            pc_en_c      = 1'b0;
            ifid_en_c    = 1'b0;
            idex_flush_c = 1'b1;
            stall_c      = 1'b1;
            state_nx     = ST_LDSTALL;
        end
    end

    assign ex_take = hz.id_valid && !stall_c && !hz.ex_redirect;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v    <= 1'b0;
            ex_rd   <= 5'd0;
            ex_wen  <= 1'b0;
            ex_ld   <= 1'b0;
            mem_v   <= 1'b0;
            mem_rd  <= 5'd0;
            mem_wen <= 1'b0;
        end else if (exmem_en_c) begin
            mem_v   <= ex_v;
            mem_rd  <= ex_rd;
            mem_wen <= ex_wen;
            ex_v    <= ex_take;
            ex_rd   <= hz.id_rd;
            ex_wen  <= hz.id_regwen;
            ex_ld   <= hz.id_is_load;
        end
    end

    assign hz.pc_en      = pc_en_c;
    assign hz.ifid_en    = ifid_en_c;
    assign hz.ifid_flush = ifid_flush_c;
    assign hz.idex_flush = idex_flush_c;
    assign hz.exmem_en   = exmem_en_c;
    assign hz.stall      = stall_c;
    assign hz.fwd_a      = rst ? 2'b00 : fwd_a_c;
    assign hz.fwd_b      = rst ? 2'b00 : fwd_b_c;

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((state == ST_LDSTALL) || (state == ST_MEMWAIT))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (hz.ex_redirect && !mem_wait)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign perf_stall_cnt = stall_cnt;
    assign perf_flush_cnt = flush_cnt;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst;
    logic [CNT_W-1:0] perf_stall_cnt;
    logic [CNT_W-1:0] perf_flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz();

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .FLUSH_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .hz             (hz),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    // Reference model: the two in-flight producers younger than WB.
    typedef struct { bit v; bit [4:0] rd; bit wen; bit ld; } instr_t;
    instr_t m_ex;
    instr_t m_mem;
    logic [CNT_W-1:0] m_stall_cnt = '0;
    logic [CNT_W-1:0] m_flush_cnt = '0;
    bit m_was_held   = 1'b0;
    bit m_perf_known = 1'b0;

    // ctrl = {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, stall}
    typedef struct {
        logic [5:0]       ctrl;
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic [CNT_W-1:0] ps;
        logic [CNT_W-1:0] pf;
        bit               chk_perf;
    } exp_t;
    exp_t exp_q[$];

    int n_chk  = 0;
    int n_pass = 0;
    bit last_hold = 1'b0;
    bit last_mw = 1'b0;
    bit last_redir_freeze = 1'b0;

    function automatic bit producer(input instr_t s, input bit used, input bit [4:0] rs);
        return used && (rs != 5'd0) && s.v && s.wen && (s.rd == rs);
    endfunction

    function automatic logic [1:0] fwd_of(input bit used, input bit [4:0] rs);
        if (producer(m_ex, used, rs) && !m_ex.ld) return 2'b10;
        if (producer(m_mem, used, rs)) return 2'b11;
        return 2'b00;
    endfunction

    task automatic cyc(input bit r, input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                       input bit [4:0] rd, input bit u1, input bit u2, input bit wen,
                       input bit ld, input bit redir, input bit macc, input bit drdy);
        exp_t e;
        bit mw, lu, stl;
        @(negedge clk);
        rst            = r;
        hz.id_valid    = v;
        hz.id_rs1      = rs1;
        hz.id_rs2      = rs2;
        hz.id_rd       = rd;
        hz.id_use_rs1  = u1;
        hz.id_use_rs2  = u2;
        hz.id_regwen   = wen;
        hz.id_is_load  = ld;
        hz.ex_redirect = redir;
        hz.mem_access  = macc;
        hz.dmem_ready  = drdy;

        mw  = macc && !drdy;
        lu  = v && m_ex.ld && (producer(m_ex, u1, rs1) || producer(m_ex, u2, rs2));
        stl = 1'b0;
        e.fa = r ? 2'b00 : fwd_of(u1, rs1);
        e.fb = r ? 2'b00 : fwd_of(u2, rs2);
        if (r)          e.ctrl = 6'b110010;
        else if (mw)    e.ctrl = 6'b000000;
        else if (redir) e.ctrl = 6'b111110;
        else if (lu) begin
            e.ctrl = 6'b000111;
            stl = 1'b1;
        end else        e.ctrl = 6'b110010;
`ifdef PIPE_PERF_EN
        e.ps = m_stall_cnt;
        e.pf = m_flush_cnt;
        e.chk_perf = m_perf_known;
`else
        e.ps = '0;
        e.pf = '0;
        e.chk_perf = 1'b1;
`endif
        exp_q.push_back(e);

        if (r) begin
            m_ex.v = 1'b0;
            m_mem.v = 1'b0;
            m_stall_cnt = '0;
            m_flush_cnt = '0;
            m_was_held = 1'b0;
            m_perf_known = 1'b1;
        end else begin
            // A stall or freeze cycle is counted during the cycle that follows it.
            if (m_was_held) m_stall_cnt = m_stall_cnt + 1;
            if (redir && !mw) m_flush_cnt = m_flush_cnt + 1;
            m_was_held = mw || stl;
            if (!mw) begin
                m_mem = m_ex;
                m_ex  = '{v && !stl && !redir, rd, wen, ld};
            end
        end
        last_hold = !r && (mw || stl);
        last_mw = !r && mw;
        last_redir_freeze = !r && mw && redir;
    endtask

    initial begin : monitor
        exp_t e;
        logic [5:0] act;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_flush, hz.exmem_en, hz.stall};
                n_chk++;
                if (act === e.ctrl) n_pass++;
                else $display("FAIL ctrl t=%0t actual=%b required=%b", $time, act, e.ctrl);
                n_chk++;
                if ({hz.fwd_a, hz.fwd_b} === {e.fa, e.fb}) n_pass++;
                else $display("FAIL fwd t=%0t actual a=%b b=%b required a=%b b=%b",
                              $time, hz.fwd_a, hz.fwd_b, e.fa, e.fb);
                if (e.chk_perf) begin
                    n_chk++;
                    if ({perf_stall_cnt, perf_flush_cnt} === {e.ps, e.pf}) n_pass++;
                    else $display("FAIL perf t=%0t actual stall=%0d flush=%0d required stall=%0d flush=%0d",
                                  $time, perf_stall_cnt, perf_flush_cnt, e.ps, e.pf);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin : stim
        bit v, u1, u2, wen, ld, r, redir, macc, drdy;
        bit [4:0] rs1, rs2, rd;
        rst = 1'b1;
        hz.id_valid = 0; hz.id_rs1 = 0; hz.id_rs2 = 0; hz.id_rd = 0;
        hz.id_use_rs1 = 0; hz.id_use_rs2 = 0; hz.id_regwen = 0; hz.id_is_load = 0;
        hz.ex_redirect = 0; hz.mem_access = 0; hz.dmem_ready = 1;
        m_ex = '{0, 0, 0, 0};
        m_mem = '{0, 0, 0, 0};

        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // add x5 ; add x6,x5,x1 -> fwd_a=10
        cyc(0, 1, 1, 2, 5, 1, 1, 1, 0, 0, 0, 1);
        cyc(0, 1, 5, 1, 6, 1, 1, 1, 0, 0, 0, 1);
        // lw x7 ; add x8,x7,x7 -> stall then 11/11
        cyc(0, 1, 6, 0, 7, 1, 0, 1, 1, 0, 0, 1);
        repeat (2) cyc(0, 1, 7, 7, 8, 1, 1, 1, 0, 0, 0, 1);
        // addi x0,x0,1 ; reader of x0
        cyc(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 9, 1, 1, 1, 0, 0, 0, 1);
        // lw x9 ; consumer in ID while redirect resolves
        cyc(0, 1, 1, 0, 9, 1, 0, 1, 1, 0, 0, 1);
        cyc(0, 1, 9, 0, 10, 1, 0, 1, 0, 1, 0, 1);
        // add x1 ; add x2 ; add x3,x2,x1 -> 10/11
        cyc(0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 2, 0, 0, 1, 0, 0, 0, 1);
        cyc(0, 1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 1);
        // store in MEM waits 3 cycles, resumes on the 4th
        repeat (3) cyc(0, 1, 3, 0, 4, 1, 0, 1, 0, 0, 1, 0);
        cyc(0, 1, 3, 0, 4, 1, 0, 1, 0, 0, 1, 1);
        // redirect held across a memory wait
        repeat (2) cyc(0, 1, 4, 0, 5, 1, 0, 1, 0, 1, 1, 0);
        cyc(0, 1, 4, 0, 5, 1, 0, 1, 0, 1, 1, 1);
        // reset while in LDSTALL
        cyc(0, 1, 0, 0, 11, 0, 0, 1, 1, 0, 0, 1);
        cyc(0, 1, 11, 0, 12, 1, 0, 1, 0, 0, 0, 1);
        cyc(1, 1, 11, 0, 12, 1, 0, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        v = 0; u1 = 0; u2 = 0; wen = 0; ld = 0; rs1 = 0; rs2 = 0; rd = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!last_hold) begin
                v   = ($urandom_range(0, 9) < 8);
                rs1 = 5'($urandom_range(0, 3));
                rs2 = 5'($urandom_range(0, 3));
                rd  = 5'($urandom_range(0, 3));
                u1  = $urandom_range(0, 1);
                u2  = $urandom_range(0, 1);
                wen = ($urandom_range(0, 9) < 7);
                ld  = ($urandom_range(0, 9) < 4);
            end
            r     = ($urandom_range(0, 99) < 2);
            redir = last_redir_freeze ? 1'b1 : ($urandom_range(0, 99) < 12);
            macc  = last_mw ? 1'b1 : ($urandom_range(0, 99) < 30);
            drdy  = ($urandom_range(0, 99) < 60);
            cyc(r, v, rs1, rs2, rd, u1, u2, wen, ld, redir, macc, drdy);
        end

        @(negedge clk);
        #5;
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
